// File: rtl/data_sram_responder.sv
// Responder end of the CPU data SRAM port: word-organised RAM with per-byte
// write enables and a programmable number of wait states before each response.
module data_sram_responder #(
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_ready,
  output logic        data_sram_ok,
  output logic        data_sram_err,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is accepted at a rising edge where data_sram_en=1 and
  // data_sram_ready=1. ready depends on state only, never on en. Exactly one
  // request is outstanding; its response is a one-cycle data_sram_ok pulse.

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [31:0] WINDOW  = 32'd4 << DEPTH_LOG2;
  localparam bit          NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] req_addr_q;
  logic [3:0]  req_wen_q;
  logic [31:0] req_wdata_q;
  logic [31:0] rdata_q;
  logic        ok_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH];

  logic                  accept;
  logic                  commit;
  logic [31:0]           c_addr;
  logic [3:0]            c_wen;
  logic [31:0]           c_wdata;
  logic [31:0]           c_offset;
  logic                  c_in_range;
  logic [DEPTH_LOG2-1:0] c_idx;

  assign data_sram_ready = (state_q == S_IDLE) || (state_q == S_RESP);
  assign accept          = data_sram_en && data_sram_ready;

  assign data_sram_rdata = rdata_q;
  assign data_sram_ok    = ok_q;
  assign data_sram_err   = err_q;
  assign dbg_state_o     = state_q;

  // Select the access that commits at this edge: the live request when there
  // are no wait states, otherwise the latched one on the last wait edge.
  always_comb begin
    commit  = 1'b0;
    c_addr  = req_addr_q;
    c_wen   = req_wen_q;
    c_wdata = req_wdata_q;
    if (NO_WAIT && accept) begin
      commit  = 1'b1;
      c_addr  = data_sram_addr;
      c_wen   = data_sram_wen;
      c_wdata = data_sram_wdata;
    end else if ((state_q == S_WAIT) && (cnt_q == 4'd1)) begin
      commit = 1'b1;
    end
  end

  // Address window decode; the two low address bits are dropped as word offset.
  always_comb begin
    c_offset   = c_addr - BASE_ADDR;
    c_in_range = (c_offset < WINDOW);
    c_idx      = c_offset[DEPTH_LOG2+1:2];
  end

  // RAM byte-lane writes; no reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (commit && c_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (c_wen[b]) mem_q[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_addr_q  <= 32'd0;
      req_wen_q   <= 4'd0;
      req_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      if (commit) begin
        ok_q    <= 1'b1;
        err_q   <= !c_in_range;
        // Reads and writes both return the pre-write word.
        rdata_q <= c_in_range ? mem_q[c_idx] : 32'd0;
      end
      case (state_q)
        S_IDLE, S_RESP: begin
          if (data_sram_en) begin
            req_addr_q  <= data_sram_addr;
            req_wen_q   <= data_sram_wen;
            req_wdata_q <= data_sram_wdata;
            if (NO_WAIT) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_LD;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // An accepted request must carry a known address.
  a_addr_known: assert property (@(posedge clock) disable iff (!reset)
    (data_sram_en && data_sram_ready) |-> !$isunknown(data_sram_addr));

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: one instance with no wait states and
// one with three wait states, sharing a clock.
module tb_data_sram_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Instance without wait states
  logic        rst0 = 1'b0, en0 = 1'b0, ready0, ok0, err0;
  logic [3:0]  wen0 = 4'd0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0, rdata0;
  logic [1:0]  st0;

  // Instance with three wait states
  logic        rst3 = 1'b0, en3 = 1'b0, ready3, ok3, err3;
  logic [3:0]  wen3 = 4'd0;
  logic [31:0] addr3 = 32'd0, wdata3 = 32'd0, rdata3;
  logic [1:0]  st3;

  data_sram_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u0 (
    .clock(clock), .reset(rst0), .data_sram_en(en0), .data_sram_wen(wen0),
    .data_sram_addr(addr0), .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
    .data_sram_ready(ready0), .data_sram_ok(ok0), .data_sram_err(err0),
    .dbg_state_o(st0)
  );

  data_sram_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u3 (
    .clock(clock), .reset(rst3), .data_sram_en(en3), .data_sram_wen(wen3),
    .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
    .data_sram_ready(ready3), .data_sram_ok(ok3), .data_sram_err(err3),
    .dbg_state_o(st3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the no-wait instance; returns at the negedge of the ok cycle.
  task automatic txn0(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clock);
    en0 = 1'b1; wen0 = wen; addr0 = addr; wdata0 = wdata;
    @(negedge clock);
    en0 = 1'b0;
  endtask

  // One request on the wait-state instance, checking the three stalled cycles;
  // returns at the negedge of the ok cycle.
  task automatic txn3(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
    @(negedge clock);
    en3 = 1'b1; wen3 = wen; addr3 = addr; wdata3 = wdata;
    @(negedge clock);
    en3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_stall_ready"}, 32'(ready3), 32'd0);
      chk({tag, "_stall_ok"}, 32'(ok3), 32'd0);
      @(negedge clock);
    end
    chk({tag, "_ok"}, 32'(ok3), 32'd1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clock);
    chk("rst0_rdata", rdata0, 32'd0);
    chk("rst0_ok", 32'(ok0), 32'd0);
    chk("rst0_err", 32'(err0), 32'd0);
    chk("rst0_ready", 32'(ready0), 32'd1);
    chk("rst0_state", 32'(st0), 32'd0);
    chk("rst3_rdata", rdata3, 32'd0);
    chk("rst3_ready", 32'(ready3), 32'd1);
    rst0 = 1'b1; rst3 = 1'b1;

    // T1: full-word write then read back, response one cycle after accept
    txn0(4'hF, 32'h10, 32'hDEAD_BEEF);
    chk("t1_wr_ok", 32'(ok0), 32'd1);
    chk("t1_wr_err", 32'(err0), 32'd0);
    chk("t1_wr_state", 32'(st0), 32'd2);
    txn0(4'h0, 32'h10, 32'h0);
    chk("t1_rd_ok", 32'(ok0), 32'd1);
    chk("t1_rd_data", rdata0, 32'hDEAD_BEEF);
    @(negedge clock);
    chk("t1_ok_pulse", 32'(ok0), 32'd0);
    chk("t1_rdata_hold", rdata0, 32'hDEAD_BEEF);
    chk("t1_idle", 32'(st0), 32'd0);

    // T2: single byte lane write returns the pre-write word
    txn0(4'b0100, 32'h10, 32'h1111_1111);
    chk("t2_wr_old", rdata0, 32'hDEAD_BEEF);
    txn0(4'h0, 32'h10, 32'h0);
    chk("t2_rd_lane", rdata0, 32'hDE11_BEEF);

    // T4: back-to-back reads with en held high
    for (int i = 0; i < 4; i++) txn0(4'hF, 32'(4 * i), 32'hA000_0000 + 32'(i));
    @(negedge clock);
    en0 = 1'b1; wen0 = 4'h0; addr0 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t4_ok", 32'(ok0), 32'd1);
      chk("t4_data", rdata0, 32'hA000_0000 + 32'(i));
      chk("t4_ready", 32'(ready0), 32'd1);
      if (i < 3) addr0 = 32'(4 * (i + 1));
      else en0 = 1'b0;
    end
    @(negedge clock);
    chk("t4_done", 32'(ok0), 32'd0);

    // Ordering: read issued in the write's response cycle sees the new data
    @(negedge clock);
    en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h20; wdata0 = 32'h1234_5678;
    @(negedge clock);
    wen0 = 4'h0;
    @(negedge clock);
    en0 = 1'b0;
    chk("ord_ok", 32'(ok0), 32'd1);
    chk("ord_data", rdata0, 32'h1234_5678);

    // T5: out-of-range read and write
    txn0(4'h0, 32'h4000, 32'h0);
    chk("t5_rd_ok", 32'(ok0), 32'd1);
    chk("t5_rd_err", 32'(err0), 32'd1);
    chk("t5_rd_data", rdata0, 32'd0);
    @(negedge clock);
    chk("t5_err_clear", 32'(err0), 32'd0);
    txn0(4'hF, 32'h4000, 32'hFFFF_FFFF);
    chk("t5_wr_err", 32'(err0), 32'd1);
    chk("t5_wr_data", rdata0, 32'd0);
    txn0(4'h0, 32'h0, 32'h0);
    chk("t5_ram_intact", rdata0, 32'hA000_0000);
    chk("t5_in_range_err", 32'(err0), 32'd0);

    // T3: three wait states
    txn3("t3_wr", 4'hF, 32'h10, 32'hCAFE_F00D);
    @(negedge clock);
    chk("t3_ok_pulse", 32'(ok3), 32'd0);
    txn3("t3_rd", 4'h0, 32'h10, 32'h0);
    chk("t3_rd_data", rdata3, 32'hCAFE_F00D);

    // T6: reset during the wait of a write discards it
    @(negedge clock);
    en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h10; wdata3 = 32'h5555_5555;
    @(negedge clock);
    en3 = 1'b0;
    chk("t6_in_wait", 32'(st3), 32'd1);
    rst3 = 1'b0;
    #1;
    chk("t6_rst_state", 32'(st3), 32'd0);
    chk("t6_rst_ok", 32'(ok3), 32'd0);
    chk("t6_rst_rdata", rdata3, 32'd0);
    @(negedge clock);
    rst3 = 1'b1;
    txn3("t6_rd", 4'h0, 32'h10, 32'h0);
    chk("t6_old_data", rdata3, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
